// File: rtl/param_rx_fifo.sv
// ============================================================================
// param_rx_fifo
// ----------------------------------------------------------------------------
// Purpose:
//    Synchronous first-word-fall-through receive FIFO with occupancy count,
//    programmable almost-full / almost-empty thresholds and sticky
//    overflow / underflow error flags.
//
// Parameters:
//    DATA_WIDTH  entry width in bits (>= 1)
//    DEPTH       number of entries (power of two, >= 2)
//    AF_LEVEL    almost_full asserts when count >= AF_LEVEL
//    AE_LEVEL    almost_empty asserts when count <= AE_LEVEL
//
// Ports:
//    clk           single clock, all state changes on its rising edge
//    n_rst         asynchronous active-low reset
//    clear         synchronous flush of pointers, count and error flags
//    w_enable      write request
//    w_data        write data
//    r_enable      read / pop request
//    r_data        oldest entry, zero while empty
//    empty         count == 0
//    full          count == DEPTH
//    almost_full   count >= AF_LEVEL
//    almost_empty  count <= AE_LEVEL
//    count         current occupancy
//    overflow      sticky, a write was rejected
//    underflow     sticky, a read was rejected
// ============================================================================
module param_rx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 64,
   parameter int AF_LEVEL   = DEPTH - 4,
   parameter int AE_LEVEL   = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    w_enable,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic                    r_enable,
   output logic [DATA_WIDTH-1:0]   r_data,
   output logic                    empty,
   output logic                    full,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  do_write;
   logic                  do_read;

   // Every status flag is a pure decode of the count register, so all flags
   // move together with count and are forced to their reset values as soon
   // as reset clears count.
   assign empty        = (count == '0);
   assign full         = (count == CW'(DEPTH));
   assign almost_full  = (int'(count) >= AF_LEVEL);
   assign almost_empty = (int'(count) <= AE_LEVEL);

   // A full FIFO can still take a write when the same edge pops the oldest
   // entry: the write lands in the slot being vacated. A read of an empty
   // FIFO is never accepted, even when a write arrives in the same cycle.
   assign do_write = w_enable && (!full || r_enable);
   assign do_read  = r_enable && !empty;

   // Fall-through read port; zero while empty so stale storage never leaks.
   assign r_data = empty ? '0 : mem[rd_ptr];

   // Storage array has no reset; only entries between the pointers are ever
   // observed. A flush suppresses the write so clear fully wins.
   always_ff @(posedge clk) begin
      if (do_write && !clear) begin
         mem[wr_ptr] <= w_data;
      end
   end

   // Pointer, occupancy and sticky error bookkeeping. Pointers wrap
   // naturally at DEPTH because DEPTH is a power of two. A simultaneous
   // accepted write and read leaves count unchanged.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (do_write) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_read) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_write && !do_read) begin
            count <= count + 1'b1;
         end else if (do_read && !do_write) begin
            count <= count - 1'b1;
         end
         if (w_enable && full && !r_enable) begin
            overflow <= 1'b1;
         end
         if (r_enable && empty) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_param_rx_fifo.sv
// ============================================================================
// tb_param_rx_fifo
// ----------------------------------------------------------------------------
// Purpose:
//    Self-checking bench for param_rx_fifo at default parameters. The
//    stimulus process keeps an abstract model (an occupancy number, two
//    sticky bits and a queue of expected data) and pushes each accepted
//    write into the scoreboard queue. A separate monitor on the falling
//    edge compares status outputs against the model and pops the
//    scoreboard whenever the DUT presents a read.
// ============================================================================
module tb_param_rx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 64;
   localparam int AF    = DEPTH - 4;
   localparam int AE    = 4;

   logic          clk;
   logic          n_rst;
   logic          clear;
   logic          w_enable;
   logic [DW-1:0] w_data;
   logic          r_enable;
   logic [DW-1:0] r_data;
   logic          empty;
   logic          full;
   logic          almost_full;
   logic          almost_empty;
   logic [6:0]    count;
   logic          overflow;
   logic          underflow;

   int            tests_run;
   int            tests_failed;

   // Reference model state: occupancy, sticky flags, expected read order.
   int            m_count;
   bit            m_ovf;
   bit            m_udf;
   logic [DW-1:0] exp_q [$];

   param_rx_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .AF_LEVEL   (AF),
      .AE_LEVEL   (AE)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (clear),
      .w_enable     (w_enable),
      .w_data       (w_data),
      .r_enable     (r_enable),
      .r_data       (r_data),
      .empty        (empty),
      .full         (full),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // 10 time-unit clock period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point; every check goes through here.
   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of requests (called at posedge+1), predict the model's
   // next state from the FIFO rules, and commit it at the next rising edge.
   task automatic apply_stimulus(input bit w, input logic [DW-1:0] d,
                                 input bit r, input bit c);
      int  nxt_count;
      bit  nxt_ovf;
      bit  nxt_udf;
      bit  acc_w;
      bit  acc_r;
      w_enable = w;
      w_data   = d;
      r_enable = r;
      clear    = c;
      if (c) begin
         nxt_count = 0;
         nxt_ovf   = 1'b0;
         nxt_udf   = 1'b0;
      end else begin
         acc_w     = w && ((m_count < DEPTH) || r);
         acc_r     = r && (m_count > 0);
         nxt_ovf   = m_ovf || (w && (m_count == DEPTH) && !r);
         nxt_udf   = m_udf || (r && (m_count == 0));
         nxt_count = m_count + int'(acc_w) - int'(acc_r);
         if (acc_w) exp_q.push_back(d);
      end
      @(posedge clk);
      m_count = nxt_count;
      m_ovf   = nxt_ovf;
      m_udf   = nxt_udf;
      if (c) exp_q.delete();
      #1;
      w_enable = 1'b0;
      r_enable = 1'b0;
      clear    = 1'b0;
   endtask

   // Monitor: compare status against the model every falling edge, compare
   // the presented head entry, and retire it when the DUT accepts a read.
   always @(negedge clk) begin
      if (n_rst) begin
         check_output("count", count, m_count);
         check_output("empty", empty, m_count == 0);
         check_output("full", full, m_count == DEPTH);
         check_output("almost_full", almost_full, m_count >= AF);
         check_output("almost_empty", almost_empty, m_count <= AE);
         check_output("overflow", overflow, m_ovf);
         check_output("underflow", underflow, m_udf);
         if (m_count == 0) begin
            check_output("r_data_empty", r_data, 0);
         end else if (exp_q.size() == 0) begin
            check_output("scoreboard_underrun", 1, 0);
         end else begin
            check_output("r_data", r_data, exp_q[0]);
         end
         if (r_enable && !clear && !empty && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      m_count      = 0;
      m_ovf        = 1'b0;
      m_udf        = 1'b0;
      n_rst        = 1'b0;
      clear        = 1'b0;
      w_enable     = 1'b0;
      r_enable     = 1'b0;
      w_data       = '0;

      // Reset state, observed before any clock edge
      #1;
      check_output("rst_count", count, 0);
      check_output("rst_empty", empty, 1);
      check_output("rst_full", full, 0);
      check_output("rst_af", almost_full, 0);
      check_output("rst_ae", almost_empty, 1);
      check_output("rst_ovf", overflow, 0);
      check_output("rst_udf", underflow, 0);
      check_output("rst_r_data", r_data, 0);
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;

      // Fill 0x00..0x3F, almost_full from count 60, then drain in order
      for (int i = 0; i < DEPTH; i++) begin
         apply_stimulus(1'b1, DW'(i), 1'b0, 1'b0);
         check_output("fill_af", almost_full, (i + 1) >= AF);
      end
      check_output("fill_full", full, 1);
      check_output("fill_count", count, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         check_output("drain_order", r_data, i);
         apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      end
      check_output("drain_empty", empty, 1);

      // Overflow: rejected 0xAA never comes back, then clear flushes
      for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, DW'($urandom_range(0, 'hA9)), 1'b0, 1'b0);
      apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b0);
      check_output("ovf_set", overflow, 1);
      check_output("ovf_count", count, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         check_output("ovf_no_aa", r_data == 8'hAA, 0);
         apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      end
      check_output("ovf_sticky", overflow, 1);
      apply_stimulus(1'b0, '0, 1'b0, 1'b1);
      check_output("clr_ovf", overflow, 0);
      check_output("clr_count", count, 0);

      // Underflow with a simultaneous write into an empty FIFO
      apply_stimulus(1'b1, 8'h5C, 1'b1, 1'b0);
      check_output("udf_set", underflow, 1);
      check_output("udf_count", count, 1);
      check_output("udf_r_data", r_data, 8'h5C);
      apply_stimulus(1'b0, '0, 1'b0, 1'b1);
      check_output("clr_udf", underflow, 0);

      // Full with both enables: count holds, head advances, 0x77 is 64th
      for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
      apply_stimulus(1'b1, 8'h77, 1'b1, 1'b0);
      check_output("both_count", count, DEPTH);
      check_output("both_head", r_data, 8'h81);
      check_output("both_no_ovf", overflow, 0);
      for (int i = 0; i < DEPTH - 1; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      check_output("both_64th", r_data, 8'h77);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);

      // Wrap-around: alternate write/read across 3*DEPTH values
      for (int k = 0; k < 3 * DEPTH; k++) begin
         apply_stimulus(1'b1, DW'(k), 1'b0, 1'b0);
         check_output("wrap_count1", count, 1);
         check_output("wrap_data", r_data, k & 8'hFF);
         apply_stimulus(1'b0, '0, 1'b1, 1'b0);
         check_output("wrap_count0", count, 0);
      end

      // Randomised traffic with phases that push toward full and empty
      for (int i = 0; i < 2000; i++) begin
         int wp;
         wp = ((i / 250) % 2 == 0) ? 80 : 25;
         apply_stimulus($urandom_range(0, 99) < wp, DW'($urandom),
                        $urandom_range(0, 99) < (100 - wp),
                        $urandom_range(0, 299) == 0);
      end

      // Asynchronous reset between edges at count 10
      apply_stimulus(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) apply_stimulus(1'b1, DW'($urandom), 1'b0, 1'b0);
      check_output("pre_rst_count", count, 10);
      #1;
      n_rst   = 1'b0;
      m_count = 0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      exp_q.delete();
      #1;
      check_output("arst_count", count, 0);
      check_output("arst_empty", empty, 1);
      check_output("arst_r_data", r_data, 0);
      check_output("arst_ae", almost_empty, 1);
      @(posedge clk);
      #1;
      n_rst = 1'b1;

      // First write after reset appears after one edge
      apply_stimulus(1'b1, 8'h3C, 1'b0, 1'b0);
      check_output("post_rst_data", r_data, 8'h3C);
      check_output("post_rst_count", count, 1);
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
